// File: rtl/euler1_sum_core.sv
// Project Euler #1 solver in a Tiny Tapeout wrapper: sums every multiple of FACTOR_A or
// FACTOR_B below LIMIT, then raises valid. The result is read 6 bits at a time through mux_sel.
module euler1_sum_core #(
  parameter int LIMIT    = 1000,
  parameter int FACTOR_A = 3,
  parameter int FACTOR_B = 5,
  parameter int ACC_W    = 18,
  parameter int CNT_W    = 11
) (
  input  logic [7:0] io_in,
  output logic [7:0] io_out
);

  localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(LIMIT);
  localparam logic [CNT_W-1:0] FA_C    = CNT_W'(FACTOR_A);
  localparam logic [CNT_W-1:0] FB_C    = CNT_W'(FACTOR_B);
  localparam int               PAD_W   = (ACC_W < 18) ? 18 : ACC_W;

  logic             clk_s;
  logic             rst_s;
  logic [1:0]       mux_sel_s;
  logic             unused_s;

  logic [CNT_W-1:0] m_a_r, m_b_r;
  logic [ACC_W-1:0] acc_r;
  logic             done_r;

  logic [CNT_W-1:0] nxt_s;
  logic [CNT_W-1:0] m_a_nxt_s, m_b_nxt_s;
  logic [ACC_W-1:0] acc_nxt_s;
  logic             done_nxt_s;
  logic [PAD_W-1:0] acc_pad_s;
  logic [5:0]       slice_s;

  assign clk_s     = io_in[0];
  assign rst_s     = io_in[1];
  assign mux_sel_s = io_in[4:3];
  // write_en and the spare pads are reserved and deliberately have no effect.
  assign unused_s  = ^{io_in[7:5], io_in[2]};

  // Walk both multiple sequences in ascending order, adding each distinct value exactly once.
  always_comb begin
    m_a_nxt_s  = m_a_r;
    m_b_nxt_s  = m_b_r;
    acc_nxt_s  = acc_r;
    done_nxt_s = done_r;
    nxt_s      = (m_a_r < m_b_r) ? m_a_r : m_b_r;
    if (done_r) begin
      done_nxt_s = 1'b1;
    end else if (nxt_s >= LIMIT_C) begin
      done_nxt_s = 1'b1;
    end else begin
      acc_nxt_s = acc_r + ACC_W'(nxt_s);
      if (m_a_r == nxt_s) begin
        m_a_nxt_s = m_a_r + FA_C;
      end else begin
        m_a_nxt_s = m_a_r;
      end
      // A common multiple advances both sequences so it is counted once.
      if (m_b_r == nxt_s) begin
        m_b_nxt_s = m_b_r + FB_C;
      end else begin
        m_b_nxt_s = m_b_r;
      end
    end
  end

  // Solver state register with asynchronous restart.
  always_ff @(posedge clk_s or posedge rst_s) begin
    if (rst_s) begin
      m_a_r  <= FA_C;
      m_b_r  <= FB_C;
      acc_r  <= {ACC_W{1'b0}};
      done_r <= 1'b0;
    end else begin
      m_a_r  <= m_a_nxt_s;
      m_b_r  <= m_b_nxt_s;
      acc_r  <= acc_nxt_s;
      done_r <= done_nxt_s;
    end
  end

  assign acc_pad_s = PAD_W'(acc_r);

  // Live readout mux; it tracks the accumulator in every state, including during reset.
  always_comb begin
    slice_s = 6'd0;
    case (mux_sel_s)
      2'd0:    slice_s = acc_pad_s[5:0];
      2'd1:    slice_s = acc_pad_s[11:6];
      2'd2:    slice_s = acc_pad_s[17:12];
      default: slice_s = 6'd0;
    endcase
  end

  assign io_out = {slice_s, 1'b0, done_r};

endmodule

// File: tb/tb_euler1_sum_core.sv
// Directed self-checking bench for euler1_sum_core: default solver plus a LIMIT=10 instance
// sharing the same pads.
module tb_euler1_sum_core;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       write_en = 1'b0;
  logic [1:0] mux_sel = 2'd0;
  logic [2:0] hi_bits = 3'd0;
  logic [7:0] io_in;
  logic [7:0] io_out;
  logic [7:0] io_out_small;

  int checks = 0;
  int errors = 0;

  assign io_in = {hi_bits, mux_sel, write_en, rst, clk};

  euler1_sum_core dut (
    .io_in  (io_in),
    .io_out (io_out)
  );

  euler1_sum_core #(.LIMIT(10)) dut_small (
    .io_in  (io_in),
    .io_out (io_out_small)
  );

  always #5 clk = ~clk;

  // Assert rst while clk is low for one cycle and release it on a falling edge.
  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Count rising edges until valid is seen (sampled 1 time unit after each edge); 0 = timeout.
  task automatic wait_valid(output int edge_n);
    edge_n = 0;
    for (int i = 1; i <= 600; i++) begin
      @(posedge clk);
      #1;
      if (io_out[0] === 1'b1) begin
        edge_n = i;
        break;
      end
    end
  endtask

  // Read the three slices and reassemble the full 18-bit result.
  task automatic read_result(output logic [5:0] s0, output logic [5:0] s1,
                             output logic [5:0] s2, output logic [17:0] full);
    mux_sel = 2'd0; #1; s0 = io_out[7:2];
    mux_sel = 2'd1; #1; s1 = io_out[7:2];
    mux_sel = 2'd2; #1; s2 = io_out[7:2];
    mux_sel = 2'd0; #1;
    full = {s2, s1, s0};
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    mux_sel = 2'd0;
    #1;
    checks++;
    if (io_out !== 8'h00) begin
      errors++;
      $display("FAIL reset_state: io_out=%h required 00", io_out);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_default_run();
    int e;
    logic [5:0] s0, s1, s2;
    logic [17:0] full;
    wait_valid(e);
    checks++;
    if (e !== 467) begin
      errors++;
      $display("FAIL default_latency: valid edge=%0d required 467", e);
    end
    read_result(s0, s1, s2, full);
    checks++;
    if (s0 !== 6'd16) begin
      errors++;
      $display("FAIL slice0: got %0d required 16", s0);
    end
    checks++;
    if (s1 !== 6'd59) begin
      errors++;
      $display("FAIL slice1: got %0d required 59", s1);
    end
    checks++;
    if (s2 !== 6'd56) begin
      errors++;
      $display("FAIL slice2: got %0d required 56", s2);
    end
    checks++;
    if (full !== 18'd233168) begin
      errors++;
      $display("FAIL default_sum: got %0d required 233168", full);
    end
    mux_sel = 2'd3;
    #1;
    checks++;
    if (io_out[7:1] !== 7'd0) begin
      errors++;
      $display("FAIL mux_sel3_zero: io_out[7:1]=%h required 00", io_out[7:1]);
    end
    mux_sel = 2'd0;
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (io_out[0] !== 1'b1 || io_out[7:2] !== 6'd16) begin
      errors++;
      $display("FAIL done_hold: valid=%b slice0=%0d required 1/16", io_out[0], io_out[7:2]);
    end
  endtask

  task automatic test_reset_after_done();
    int e;
    logic [5:0] s0, s1, s2;
    logic [17:0] full;
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (io_out[0] !== 1'b0 || io_out[7:2] !== 6'd0) begin
      errors++;
      $display("FAIL reset_after_done_async: valid=%b slice0=%0d required 0/0", io_out[0], io_out[7:2]);
    end
    @(negedge clk);
    rst = 1'b0;
    wait_valid(e);
    checks++;
    if (e !== 467) begin
      errors++;
      $display("FAIL rerun_latency: valid edge=%0d required 467", e);
    end
    read_result(s0, s1, s2, full);
    checks++;
    if (full !== 18'd233168) begin
      errors++;
      $display("FAIL rerun_sum: got %0d required 233168", full);
    end
  endtask

  task automatic test_reset_mid_run();
    int e;
    logic [5:0] s0, s1, s2;
    logic [17:0] full;
    pulse_reset();
    repeat (200) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    mux_sel = 2'd1;
    #1;
    checks++;
    if (io_out[0] !== 1'b0 || io_out[7:2] !== 6'd0) begin
      errors++;
      $display("FAIL mid_reset_async: valid=%b slice1=%0d required 0/0", io_out[0], io_out[7:2]);
    end
    mux_sel = 2'd0;
    @(negedge clk);
    rst = 1'b0;
    wait_valid(e);
    checks++;
    if (e !== 467) begin
      errors++;
      $display("FAIL mid_reset_latency: valid edge=%0d required 467", e);
    end
    read_result(s0, s1, s2, full);
    checks++;
    if (full !== 18'd233168) begin
      errors++;
      $display("FAIL mid_reset_sum: got %0d required 233168", full);
    end
  endtask

  task automatic test_ignored_inputs();
    int e;
    logic [5:0] s0, s1, s2;
    logic [17:0] full;
    pulse_reset();
    e = 0;
    for (int i = 1; i <= 600; i++) begin
      @(posedge clk);
      #1;
      if (io_out[1] !== 1'b0) begin
        errors++;
        checks++;
        $display("FAIL io_out1_zero: io_out[1]=%b required 0 at edge %0d", io_out[1], i);
      end
      if (io_out[0] === 1'b1) begin
        e = i;
        break;
      end
      write_en = ~write_en;
      hi_bits  = hi_bits + 3'd3;
    end
    write_en = 1'b0;
    hi_bits  = 3'd0;
    checks++;
    if (e !== 467) begin
      errors++;
      $display("FAIL ignored_inputs_latency: valid edge=%0d required 467", e);
    end
    read_result(s0, s1, s2, full);
    checks++;
    if (full !== 18'd233168) begin
      errors++;
      $display("FAIL ignored_inputs_sum: got %0d required 233168", full);
    end
  endtask

  task automatic test_small_limit();
    int e;
    pulse_reset();
    e = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      #1;
      if (io_out_small[0] === 1'b1) begin
        e = i;
        break;
      end
    end
    checks++;
    if (e !== 5) begin
      errors++;
      $display("FAIL small_latency: valid edge=%0d required 5", e);
    end
    mux_sel = 2'd0;
    #1;
    checks++;
    if (io_out_small[7:2] !== 6'd23) begin
      errors++;
      $display("FAIL small_slice0: got %0d required 23", io_out_small[7:2]);
    end
    mux_sel = 2'd1;
    #1;
    checks++;
    if (io_out_small[7:2] !== 6'd0) begin
      errors++;
      $display("FAIL small_slice1: got %0d required 0", io_out_small[7:2]);
    end
    mux_sel = 2'd0;
  endtask

  initial begin
    test_reset();
    test_default_run();
    test_reset_after_done();
    test_reset_mid_run();
    test_ignored_inputs();
    test_small_limit();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
